// File: rtl/piso_pkg.sv
// Shared constants and helpers for the parallel-in / serial-out shift register.
package piso_pkg;

   localparam int unsigned PISO_DEFAULT_WIDTH = 4;

   // Width of a counter able to hold the values 0..w inclusive.
   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w + 1);
   endfunction

endpackage : piso_pkg

// File: rtl/piso_bit_counter.sv
// Saturating down-counter with load, async clear, and a nonzero flag.
module piso_bit_counter
   import piso_pkg::*;
#(
   parameter  int unsigned MAX   = PISO_DEFAULT_WIDTH,
   localparam int unsigned CNT_W = cnt_width(MAX)
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             load,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             nonzero
);

   // Load wins over decrement; decrement stops at zero.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         count <= '0;
      end else if (load) begin
         count <= CNT_W'(MAX);
      end else if (dec && (count != '0)) begin
         count <= count - CNT_W'(1);
      end
   end

   assign nonzero = (count != '0);

endmodule : piso_bit_counter

// File: rtl/piso_shift_reg.sv
// Parallel-in, serial-out shift register with a remaining-bit counter.
module piso_shift_reg
   import piso_pkg::*;
#(
   parameter  int unsigned WIDTH     = PISO_DEFAULT_WIDTH,
   parameter  bit          MSB_FIRST = 1'b1,
   localparam int unsigned CNT_W     = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             en,
   input  logic [WIDTH-1:0] p_in,
   output logic             s_out,
   output logic             s_valid,
   output logic [CNT_W-1:0] bits_left
);

   logic [WIDTH-1:0] sreg;

   // p_in is only sampled on a load, so X on it cannot leak in while shifting.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         sreg <= '0;
      end else if (en) begin
         sreg <= p_in;
      end else if (MSB_FIRST) begin
         sreg <= {sreg[WIDTH-2:0], 1'b0};
      end else begin
         sreg <= {1'b0, sreg[WIDTH-1:1]};
      end
   end

   assign s_out = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];

   piso_bit_counter #(
      .MAX (WIDTH)
   ) u_bit_counter (
      .clk     (clk),
      .clear   (clear),
      .load    (en),
      .dec     (~en),
      .count   (bits_left),
      .nonzero (s_valid)
   );

endmodule : piso_shift_reg

// File: tb/tb_piso_shift_reg.sv
// Scoreboard bench: MSB-first and LSB-first instances driven in lockstep against a bit-queue model.
module tb_piso_shift_reg;

   localparam int unsigned W  = 4;
   localparam int unsigned CW = $clog2(W + 1);

   typedef struct {
      logic          so_m;
      logic          sv_m;
      logic [CW-1:0] bl_m;
      logic          so_l;
      logic          sv_l;
      logic [CW-1:0] bl_l;
   } exp_t;

   logic          clk   = 1'b0;
   logic          clear = 1'b0;
   logic          en    = 1'b0;
   logic [W-1:0]  p_in  = '0;
   logic          s_out_m, s_valid_m, s_out_l, s_valid_l;
   logic [CW-1:0] bits_left_m, bits_left_l;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   event chk_ev;

   // Model: the bits still to be emitted, in serial order.
   logic bits_m[$];
   logic bits_l[$];

   always #5 clk = ~clk;

   piso_shift_reg #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .clear(clear), .en(en), .p_in(p_in),
      .s_out(s_out_m), .s_valid(s_valid_m), .bits_left(bits_left_m));

   piso_shift_reg #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .clear(clear), .en(en), .p_in(p_in),
      .s_out(s_out_l), .s_valid(s_valid_l), .bits_left(bits_left_l));

   function automatic exp_t model_view();
      exp_t e;
      e.so_m = (bits_m.size() != 0) ? bits_m[0] : 1'b0;
      e.sv_m = (bits_m.size() != 0);
      e.bl_m = CW'(bits_m.size());
      e.so_l = (bits_l.size() != 0) ? bits_l[0] : 1'b0;
      e.sv_l = (bits_l.size() != 0);
      e.bl_l = CW'(bits_l.size());
      return e;
   endfunction

   function automatic void model_edge(input logic c, input logic e, input logic [W-1:0] p);
      if (c) begin
         bits_m.delete();
         bits_l.delete();
      end else if (e) begin
         bits_m.delete();
         bits_l.delete();
         for (int i = W - 1; i >= 0; i--) bits_m.push_back(p[i]);
         for (int i = 0; i < W; i++)      bits_l.push_back(p[i]);
      end else begin
         if (bits_m.size() != 0) void'(bits_m.pop_front());
         if (bits_l.size() != 0) void'(bits_l.pop_front());
      end
   endfunction

   // One clock: apply inputs, model the edge, queue the expected post-edge view.
   task automatic step(input logic c, input logic e, input logic [W-1:0] p);
      clear = c;
      en    = e;
      p_in  = p;
      @(posedge clk);
      model_edge(c, e, p);
      sb.push_back(model_view());
      @(negedge clk);
      #1;
   endtask

   task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares whenever an expectation is pending, at mid-cycle or on demand.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk or chk_ev);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            cmp("msb_s_out",     8'(s_out_m),     8'(e.so_m));
            cmp("msb_s_valid",   8'(s_valid_m),   8'(e.sv_m));
            cmp("msb_bits_left", 8'(bits_left_m), 8'(e.bl_m));
            cmp("lsb_s_out",     8'(s_out_l),     8'(e.so_l));
            cmp("lsb_s_valid",   8'(s_valid_l),   8'(e.sv_l));
            cmp("lsb_bits_left", 8'(bits_left_l), 8'(e.bl_l));
         end
      end
   end

   initial begin
      logic          c, e;
      logic [W-1:0]  p;
      #1 clear = 1'b1;
      @(negedge clk);
      #1;

      // Clear dominates a held load request.
      step(1'b1, 1'b1, 4'b1011);
      step(1'b1, 1'b1, 4'b1011);

      // Load then drain past empty.
      step(1'b0, 1'b1, 4'b1011);
      repeat (5) step(1'b0, 1'b0, 4'bxxxx);

      // Held load tracks p_in.
      step(1'b0, 1'b1, 4'b0001);
      step(1'b0, 1'b1, 4'b1000);
      step(1'b0, 1'b1, 4'b0110);

      // Async clear between edges.
      step(1'b0, 1'b1, 4'b1111);
      step(1'b0, 1'b0, 4'bxxxx);
      step(1'b0, 1'b0, 4'bxxxx);
      clear = 1'b1;
      #1;
      model_edge(1'b1, 1'b0, '0);
      sb.push_back(model_view());
      -> chk_ev;
      @(negedge clk);
      #1;
      step(1'b1, 1'b0, 4'b0000);

      // Reload mid-shift.
      step(1'b0, 1'b1, 4'b1011);
      step(1'b0, 1'b0, 4'bxxxx);
      step(1'b0, 1'b1, 4'b0100);
      repeat (4) step(1'b0, 1'b0, 4'bxxxx);

      // Randomized traffic, with X on p_in while shifting.
      for (int n = 0; n < 400; n++) begin
         c = ($urandom_range(0, 39) == 0);
         e = ($urandom_range(0, 4) == 0);
         p = W'($urandom);
         if (!e && $urandom_range(0, 1) == 1) p = 'x;
         step(c, e, p);
      end

      for (int t = 0; t < 10 && sb.size() != 0; t++) @(negedge clk);
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      #2;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_piso_shift_reg
